ksa_param: RTL and testbench
============================

// Module: ksa_param
// PURPOSE
//  Parametrised RC4 key-scheduling engine. Runs the full 256-iteration KSA
//  (j += S[i] + key[i mod KEY_BYTES]; swap S[i],S[j]) on an external 256x8
//  single-port S RAM. Supports configurable key length and RAM read latency.
//  Sits between the key-search controller (en/rdy) and the S memory, ahead of the PRGA.
// PARAMETERS
//  KEY_BYTES  3  key length in bytes, 1..32; key byte 0 = key[8*KEY_BYTES-1 -: 8]
//  RD_LAT     1  S RAM read latency in cycles, 1..2 (rddata valid RD_LAT cycles after addr)
// PORTS
//  clk     in   1             system clock, all logic on rising edge
//  rst_n   in   1             asynchronous active-low reset
//  en      in   1             start request, sampled only while rdy=1
//  rdy     out  1             1 = idle, ready to accept en
//  key     in   8*KEY_BYTES   secret key, latched on the accepted en cycle
//  addr    out  8             S RAM address
//  rddata  in   8             S RAM read data
//  wrdata  out  8             S RAM write data
//  wren    out  1             S RAM write enable
// BEHAVIOUR
//  - Reset (async, rst_n=0): rdy=1, addr=0, wrdata=0, wren=0, i=0, j=0, kidx=0, state IDLE.
//  - Handshake: en=1 && rdy=1 at an edge -> latch key, rdy=0 next cycle, start run.
//    en while rdy=0 is ignored. rdy rises after the final write. Back-to-back runs allowed.
//  - States per iteration i (i 0..255):
//    RI   addr=i, wren=0
//    WI1  (RD_LAT=2 only) wait
//    CJ   si<=rddata; j<=j+rddata+kbyte[kidx] (mod 256)
//    RJ   addr=j, wren=0
//    WJ1  (RD_LAT=2 only) wait
//    CS   sj<=rddata
//    WRI  addr=i, wrdata=sj, wren=1
//    WRJ  addr=j, wrdata=si, wren=1; i++, kidx++ (kidx wraps at KEY_BYTES-1 -> 0)
//    After WRJ: go to RI, or to IDLE when i was 255.
//  - Iteration = 4+2*RD_LAT cycles. Run = 256*(4+2*RD_LAT) cycles, en edge to rdy=1.
//  - Arithmetic: all 8-bit modulo 256. i and j wrap naturally. No divider; kidx is a counter.
//  - i==j: both writes hit the same address with the same value. Legal, no special case.
//  - wren is high only in WRI/WRJ (and INIT). addr/wrdata in other cycles are don't-care
//    except as listed above.
//  - Reset mid-run: abort immediately to IDLE with reset values. RAM content is undefined.
//  - key changes after acceptance have no effect until the next run.
//  - In IDLE: wren=0, and addr holds its last value.
// CONFIGURATION
//  KSA_INIT_EN defined: an INIT phase runs first after acceptance. It spends 256 cycles
//    writing S[k]=k (addr=k, wrdata=k, wren=1, k 0..255), then enters RI with i=j=0.
//    Run length = 256 + 256*(4+2*RD_LAT) cycles.
//  KSA_INIT_EN undefined: no INIT phase. S must be preloaded with identity by the caller.
// TESTING
//  1 Reset release -> rdy=1, wren=0, addr=0. Hold en=0 for 10 cycles -> rdy stays 1 and
//    no writes occur.
//  2 KEY_BYTES=1, RD_LAT=1, S=identity, key=8'h00 -> i=1 writes (1,1),(1,1) (i==j).
//    i=2 writes (2,3),(3,2). i=3 writes (3,5),(5,2). rdy=1 exactly 1536 cycles after en.
//  3 KEY_BYTES=3, key=24'h4B6579 ("Key"): final 256-byte S must match the software model.
//    PRGA on it yields EB 9F 77 81.
//  4 RD_LAT=2 -> rdy returns 2048 cycles after en, and S matches scenario 3.
//  5 en pulses while rdy=0, plus a key change mid-run -> ignored; result identical to
//    scenario 3.
//  6 rst_n low at iteration 100 -> same cycle: rdy=1, wren=0. A fresh run afterwards
//    matches the model.
//  7 KSA_INIT_EN defined: first 256 cycles write addr=k, data=k. Total 1792 cycles
//    (RD_LAT=1). S matches scenario 3 from any initial RAM content.

Source files
------------

// File: rtl/ksa_param.sv
// RC4 key schedule on an external 256x8 S RAM; KSA_INIT_EN adds an S[k]=k fill phase first.
// Run = 256*(4+2*RD_LAT) cycles (+256 with init) from accepted en to rdy; en ignored while busy.
module ksa_param #(
  parameter int KEY_BYTES = 3,
  parameter int RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             addr,
  input  logic [7:0]             rddata,
  output logic [7:0]             wrdata,
  output logic                   wren
);
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {IDLE, INIT, RI, WI1, CJ, RJ, WJ1, CS, WRI, WRJ} state_t;

  state_t                 state_q, state_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [7:0]             si_q, si_d;
  logic [7:0]             sj_q, sj_d;
  logic [KW-1:0]          kidx_q, kidx_d;
  logic [7:0]             addr_q, addr_d;
  logic [7:0]             wrdata_q, wrdata_d;
  logic                   wren_q, wren_d;
  logic [7:0]             kbyte;

  // Key byte 0 sits in the most significant byte of the key bus.
  always_comb begin
    kbyte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (kidx_q == KW'(b)) kbyte = key_q[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          key_d  = key;
          i_d    = '0;
          j_d    = '0;
          kidx_d = '0;
`ifdef KSA_INIT_EN
          state_d = INIT;
`else
          state_d = RI;
`endif
        end
      end
      INIT: begin
        i_d = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = RI;
      end
      RI:  state_d = (RD_LAT == 2) ? WI1 : CJ;
      WI1: state_d = CJ;
      CJ: begin
        si_d    = rddata;
        j_d     = j_q + rddata + kbyte;
        state_d = RJ;
      end
      RJ:  state_d = (RD_LAT == 2) ? WJ1 : CS;
      WJ1: state_d = CS;
      CS: begin
        sj_d    = rddata;
        state_d = WRI;
      end
      WRI: state_d = WRJ;
      WRJ: begin
        i_d     = i_q + 8'd1;
        kidx_d  = (kidx_q == KW'(KEY_BYTES-1)) ? '0 : kidx_q + KW'(1);
        state_d = (i_q == 8'hFF) ? IDLE : RI;
      end
      default: state_d = IDLE;
    endcase

    // RAM strobes are registered, so they are decoded from the state being entered.
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    case (state_d)
      INIT: begin
        addr_d   = i_d;
        wrdata_d = i_d;
        wren_d   = 1'b1;
      end
      RI: addr_d = i_d;
      RJ: addr_d = j_d;
      WRI: begin
        addr_d   = i_q;
        wrdata_d = sj_d;
        wren_d   = 1'b1;
      end
      WRJ: begin
        addr_d   = j_q;
        wrdata_d = si_q;
        wren_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      key_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      kidx_q   <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      i_q      <= i_d;
      j_q      <= j_d;
      si_q     <= si_d;
      sj_q     <= sj_d;
      kidx_q   <= kidx_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
    end
  end

  assign rdy    = (state_q == IDLE);
  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;

endmodule

// File: tb/tb_ksa_param.sv
// Bench for ksa_param: three instances (1-byte key, 3-byte key, 3-byte key with 2-cycle RAM),
// each on its own S RAM model, checked every cycle against a software KSA write sequence.
module tb_ksa_param;
  logic clk;
  logic rst_n;
  logic [2:0]       en, rdy, wren;
  logic [2:0][23:0] key;
  logic [2:0][7:0]  addr, wrdata, rd1, rd2;
  logic [7:0]       mem [3][256];
  logic             pre_req;
  int               pre_idx;
  logic [7:0]       pre_val [256];
  int               vec, bad, init_len;
  logic [7:0]       exp_a [$];
  logic [7:0]       exp_d [$];
  logic [7:0]       s_exp [256];
  logic [7:0]       cap_a [1024];
  logic [7:0]       cap_d [1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ksa_param #(.KEY_BYTES(1), .RD_LAT(1)) u_k1 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .rdy(rdy[0]), .key(key[0][7:0]),
    .addr(addr[0]), .rddata(rd1[0]), .wrdata(wrdata[0]), .wren(wren[0]));
  ksa_param #(.KEY_BYTES(3), .RD_LAT(1)) u_k3 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .rdy(rdy[1]), .key(key[1]),
    .addr(addr[1]), .rddata(rd1[1]), .wrdata(wrdata[1]), .wren(wren[1]));
  ksa_param #(.KEY_BYTES(3), .RD_LAT(2)) u_k3l2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .rdy(rdy[2]), .key(key[2]),
    .addr(addr[2]), .rddata(rd2[2]), .wrdata(wrdata[2]), .wren(wren[2]));

  // S RAMs: one write port, read data one cycle (rd1) or two cycles (rd2) after addr.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (pre_req && pre_idx == k) begin
        for (int n = 0; n < 256; n++) mem[k][n] <= pre_val[n];
      end else if (wren[k]) begin
        mem[k][addr[k]] <= wrdata[k];
      end
      rd1[k] <= mem[k][addr[k]];
      rd2[k] <= rd1[k];
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    vec++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  // Full run on instance idx; rst_cyc >= 0 pulls reset at that cycle and abandons the run.
  task automatic run_ksa(input int idx, input logic [23:0] k, input int kb, input int rl,
                         input bit disturb, input int rst_cyc);
    logic [7:0] s [256];
    logic [7:0] j, kv, t;
    int L, run_len, wp, nmis;
    bit ew;
    L       = 4 + 2*rl;
    run_len = init_len + 256*L;
    exp_a.delete();
    exp_d.delete();
    for (int n = 0; n < 256; n++) begin
      s[n]       = 8'(n);
      pre_val[n] = (init_len > 0) ? 8'($urandom) : 8'(n);
      if (init_len > 0) begin
        exp_a.push_back(8'(n));
        exp_d.push_back(8'(n));
      end
    end
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kv = k[8*(kb-1-(i%kb)) +: 8];
      j  = j + s[i] + kv;
      exp_a.push_back(8'(i)); exp_d.push_back(s[j]);
      exp_a.push_back(j);     exp_d.push_back(s[i]);
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int n = 0; n < 256; n++) s_exp[n] = s[n];

    @(negedge clk); pre_idx = idx; pre_req = 1'b1;
    @(negedge clk); pre_req = 1'b0;
    chk($sformatf("start_rdy[%0d]", idx), int'(rdy[idx]), 1);
    key[idx] = k;
    en[idx]  = 1'b1;

    wp = 0;
    for (int c = 0; c <= run_len; c++) begin
      @(negedge clk);
      en[idx] = 1'b0;
      ew = (c < init_len) || (c < run_len && ((c - init_len) % L) >= L - 2);
      chk($sformatf("rdy[%0d]@%0d", idx, c), int'(rdy[idx]), int'(c >= run_len));
      chk($sformatf("wren[%0d]@%0d", idx, c), int'(wren[idx]), int'(ew));
      if (ew && wren[idx]) begin
        if (wp < exp_a.size()) begin
          chk($sformatf("waddr[%0d]#%0d", idx, wp), int'(addr[idx]), int'(exp_a[wp]));
          chk($sformatf("wdata[%0d]#%0d", idx, wp), int'(wrdata[idx]), int'(exp_d[wp]));
          cap_a[wp] = addr[idx];
          cap_d[wp] = wrdata[idx];
        end
        wp++;
      end
      if (disturb && c < run_len - 4) begin
        en[idx] = (c % 97 == 5);
        if (c == 700) key[idx] = ~k;
      end
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk($sformatf("abort_rdy[%0d]", idx), int'(rdy[idx]), 1);
        chk($sformatf("abort_wren[%0d]", idx), int'(wren[idx]), 0);
        chk($sformatf("abort_addr[%0d]", idx), int'(addr[idx]), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
    end
    chk($sformatf("nwrites[%0d]", idx), wp, exp_a.size());
    nmis = 0;
    for (int n = 0; n < 256; n++) if (mem[idx][n] !== s_exp[n]) nmis++;
    chk($sformatf("final_S_bad_bytes[%0d]", idx), nmis, 0);
  endtask

  initial begin
    logic [7:0] la [6];
    logic [7:0] ld [6];
    logic [7:0] ev [4];
    logic [7:0] s [256];
    logic [7:0] pi, pj, t;

    vec = 0; bad = 0;
    rst_n = 1'b0; en = '0; key = '0; pre_req = 1'b0; pre_idx = 0;
`ifdef KSA_INIT_EN
    init_len = 256;
`else
    init_len = 0;
`endif
    #3;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rdy[%0d]", k), int'(rdy[k]), 1);
      chk($sformatf("rst_wren[%0d]", k), int'(wren[k]), 0);
      chk($sformatf("rst_addr[%0d]", k), int'(addr[k]), 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("idle_rdy[%0d]@%0d", k, c), int'(rdy[k]), 1);
        chk($sformatf("idle_wren[%0d]@%0d", k, c), int'(wren[k]), 0);
      end
    end

    // One-byte zero key: iterations 1..3 produce these writes.
    run_ksa(0, 24'h000000, 1, 1, 1'b0, -1);
    la = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd5};
    ld = '{8'd1, 8'd1, 8'd3, 8'd2, 8'd5, 8'd2};
    for (int n = 0; n < 6; n++) begin
      chk($sformatf("lit_addr#%0d", n), int'(cap_a[init_len+2+n]), int'(la[n]));
      chk($sformatf("lit_data#%0d", n), int'(cap_d[init_len+2+n]), int'(ld[n]));
    end

    // "Key": RC4 keystream from the scheduled S starts EB 9F 77 81.
    run_ksa(1, 24'h4B6579, 3, 1, 1'b0, -1);
    ev = '{8'hEB, 8'h9F, 8'h77, 8'h81};
    for (int n = 0; n < 256; n++) s[n] = mem[1][n];
    pi = 8'd0; pj = 8'd0;
    for (int n = 0; n < 4; n++) begin
      pi = pi + 8'd1;
      pj = pj + s[pi];
      t = s[pi]; s[pi] = s[pj]; s[pj] = t;
      t = s[pi] + s[pj];
      chk($sformatf("prga#%0d", n), int'(s[t]), int'(ev[n]));
    end

    run_ksa(2, 24'h4B6579, 3, 2, 1'b0, -1);
    run_ksa(1, 24'h4B6579, 3, 1, 1'b1, -1);
    run_ksa(1, 24'h4B6579, 3, 1, 1'b0, init_len + 100*6 + 4);
    run_ksa(1, 24'h4B6579, 3, 1, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
